// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Module : quad_pkg
// Brief  : Phase encodings, step classes and Gray-order helpers for quadrature decode.
// Rev    : 1.0 - initial release
// ============================================================================
package quad_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } step_cls_t;

  function automatic phase_t next_fwd(input phase_t ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // A reverse step is a forward step seen from the new phase.
  function automatic step_cls_t classify(input phase_t prev, input phase_t cur);
    if (cur == prev)                return STEP_NONE;
    else if (cur == next_fwd(prev)) return STEP_UP;
    else if (prev == next_fwd(cur)) return STEP_DN;
    else                            return STEP_ERR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_step_decoder_if.sv
`default_nettype none
// ============================================================================
// Module : quad_step_decoder_if
// Brief  : Pin, control and up/down step bundle of the quadrature decoder.
// Rev    : 1.0 - initial release
// ============================================================================
interface quad_step_decoder_if #(
  parameter int CNT_W = 4
);
  logic             a;
  logic             b;
  logic             clr;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step;
  logic             err;
  logic             err_sticky;

  // master is the decoder (source of the step stream), slave its host
  modport master (
    input  a, b, clr, load, load_val,
    output count, dir, step, err, err_sticky
  );

  modport slave (
    output a, b, clr, load, load_val,
    input  count, dir, step, err, err_sticky
  );
endinterface
`default_nettype wire

// File: rtl/quad_sync.sv
`default_nettype none
// ============================================================================
// Module : quad_sync
// Brief  : Single-bit multi-flop synchroniser, asynchronous active-low reset to 0.
// Rev    : 1.0 - initial release
// ============================================================================
module quad_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module : quad_step_decoder
// Brief  : Quadrature a/b decoder producing dir/step/err pulses and a position count.
// Rev    : 1.0 - initial release
// ============================================================================
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  quad_step_decoder_if.master bus
);

  localparam int FW = $clog2(SYNC_STAGES);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic             w_sa;
  logic             w_sb;
  phase_t           w_cur;
  step_cls_t        w_cls;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [FW-1:0]    r_fill;
  logic [FW-1:0]    w_fill_nxt;
  logic             w_capture;
  logic             w_eval;
  phase_t           r_prev;
  logic [CNT_W-1:0] r_count;
  logic             r_dir;
  logic             r_step;
  logic             r_err;
  logic             r_err_sticky;

  quad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (bus.a),
    .q   (w_sa)
  );

  quad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (bus.b),
    .q   (w_sb)
  );

  assign w_cur = phase_t'({w_sa, w_sb});
  assign w_cls = classify(r_prev, w_cur);

  // Priming waits until the synchroniser holds real pin data, so a pin
  // level held through reset release is captured rather than seen as a jump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FILL;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    case (r_state)
      ST_FILL: begin
        if (r_fill == FW'(SYNC_STAGES - 1)) begin
          w_state_nxt = ST_PRIME;
          w_fill_nxt  = '0;
        end else begin
          w_fill_nxt  = r_fill + FW'(1);
        end
      end
      ST_PRIME: w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    w_capture = (r_state == ST_PRIME);
    w_eval    = (r_state == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev       <= PH_00;
      r_count      <= '0;
      r_dir        <= 1'b0;
      r_step       <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_err  <= 1'b0;

      if (w_capture || w_eval) begin
        r_prev <= w_cur;
      end

      if (w_eval) begin
        case (w_cls)
          STEP_UP: begin
            r_step <= 1'b1;
            r_dir  <= 1'b1;
          end
          STEP_DN: begin
            r_step <= 1'b1;
            r_dir  <= 1'b0;
          end
          STEP_ERR: r_err <= 1'b1;
          default:  ;
        endcase
      end

      // clr beats load beats the decoded step
      if (bus.clr) begin
        r_count <= '0;
      end else if (bus.load) begin
        r_count <= bus.load_val;
      end else if (w_eval && (w_cls == STEP_UP)) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_eval && (w_cls == STEP_DN)) begin
        r_count <= r_count - CNT_W'(1);
      end

      if (bus.clr) begin
        r_err_sticky <= 1'b0;
      end else if (w_eval && (w_cls == STEP_ERR)) begin
        r_err_sticky <= 1'b1;
      end
    end
  end

  assign bus.count      = r_count;
  assign bus.dir        = r_dir;
  assign bus.step       = r_step;
  assign bus.err        = r_err;
  assign bus.err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_quad_step_decoder
// Brief  : Directed bench for quad_step_decoder with a behavioural reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_quad_step_decoder;

  localparam int CNT_W = 4;
  localparam int S     = 2;
  localparam int MOD   = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  quad_step_decoder_if #(.CNT_W(CNT_W)) bus ();

  quad_step_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_step = 0;
  int n_err  = 0;

  // reference model state
  bit [1:0] m_hist[$];
  bit       m_primed;
  bit [1:0] m_prev;
  int       m_count;
  bit       m_dir, m_step, m_err, m_sticky;

  function automatic int gray_pos(input bit [1:0] ph);
    case (ph)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_primed = 1'b0;
    m_prev   = 2'b00;
    m_count  = 0;
    m_dir    = 1'b0;
    m_step   = 1'b0;
    m_err    = 1'b0;
    m_sticky = 1'b0;
  endtask

  // Decoder sees the pins sampled S edges earlier; first valid sample primes.
  task automatic model_update();
    bit [1:0] cur;
    int       d;
    bit       up, dn;
    up = 1'b0;
    dn = 1'b0;
    if (!rst) begin
      model_reset();
      return;
    end
    m_step = 1'b0;
    m_err  = 1'b0;
    m_hist.push_back({bus.a, bus.b});
    if (m_hist.size() > S) begin
      cur = m_hist.pop_front();
      if (!m_primed) begin
        m_primed = 1'b1;
      end else begin
        d  = (gray_pos(cur) - gray_pos(m_prev) + 4) % 4;
        up = (d == 1);
        dn = (d == 3);
        if (d == 2) m_err = 1'b1;
      end
      m_prev = cur;
    end
    if (up || dn) begin
      m_step = 1'b1;
      m_dir  = up;
    end
    if (bus.clr)       m_count = 0;
    else if (bus.load) m_count = int'(bus.load_val);
    else if (up)       m_count = (m_count + 1) % MOD;
    else if (dn)       m_count = (m_count + MOD - 1) % MOD;
    if (bus.clr)    m_sticky = 1'b0;
    else if (m_err) m_sticky = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_update();
    check("count",      bus.count,      m_count);
    check("dir",        bus.dir,        m_dir);
    check("step",       bus.step,       m_step);
    check("err",        bus.err,        m_err);
    check("err_sticky", bus.err_sticky, m_sticky);
    if (bus.step === 1'b1) n_step++;
    if (bus.err === 1'b1)  n_err++;
  endtask

  task automatic hold(input bit [1:0] ph, input int n);
    bus.a = ph[1];
    bus.b = ph[0];
    repeat (n) cyc();
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = CNT_W'(v);
    cyc();
    bus.load     = 1'b0;
  endtask

  initial begin
    bus.a        = 1'b1;
    bus.b        = 1'b1;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    model_reset();

    repeat (3) cyc();
    check("rst_count",  bus.count, 0);
    check("rst_sticky", bus.err_sticky, 0);

    // release with 11 held: no err
    #2 rst = 1'b1;
    n_err = 0;
    repeat (10) cyc();
    check("steady11_no_err", n_err, 0);
    check("steady11_count",  bus.count, 0);
    check("steady11_sticky", bus.err_sticky, 0);

    // walk back to 00, clear, then a full forward cycle
    hold(2'b01, 4);
    hold(2'b00, 4);
    check("rev_to00_count", bus.count, 14);
    pulse_clr();
    check("clr_count", bus.count, 0);

    n_step = 0;
    bus.a = 1'b0;
    bus.b = 1'b1;
    cyc();
    cyc();
    check("lat_no_step_yet", bus.step, 0);
    cyc();
    check("lat_step_3rd", bus.step, 1);
    cyc();
    hold(2'b11, 4);
    hold(2'b10, 4);
    hold(2'b00, 4);
    check("fwd_steps", n_step, 4);
    check("fwd_count", bus.count, 4);
    check("fwd_dir",   bus.dir, 1);

    // reverse from 1 wraps through 0
    do_load(1);
    hold(2'b10, 4);
    hold(2'b11, 4);
    check("rev_wrap_count", bus.count, 15);
    check("rev_dir",        bus.dir, 0);

    // illegal jump 00->11
    hold(2'b01, 4);
    hold(2'b00, 4);
    n_err = 0;
    hold(2'b11, 6);
    check("jump_err_once", n_err, 1);
    check("jump_count",    bus.count, 13);
    check("jump_dir",      bus.dir, 0);
    check("jump_sticky",   bus.err_sticky, 1);
    pulse_clr();
    check("sticky_cleared", bus.err_sticky, 0);

    // load coincident with a forward step 11->10
    bus.a = 1'b1;
    bus.b = 1'b0;
    cyc();
    cyc();
    do_load(9);
    check("load_vs_step_count", bus.count, 9);
    check("load_vs_step_pulse", bus.step, 1);
    cyc();

    bus.clr      = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = CNT_W'(5);
    cyc();
    bus.clr  = 1'b0;
    bus.load = 1'b0;
    check("clr_over_load", bus.count, 0);

    // err coincident with clr: pulse fires, sticky stays clear
    bus.a = 1'b0;
    bus.b = 1'b1;
    cyc();
    cyc();
    pulse_clr();
    check("clr_err_pulse",  bus.err, 1);
    check("clr_err_sticky", bus.err_sticky, 0);
    cyc();

    // asynchronous reset mid-operation at count=7
    do_load(7);
    check("pre_rst_count", bus.count, 7);
    #3 rst = 1'b0;
    #1;
    check("async_rst_count", bus.count, 0);
    check("async_rst_dir",   bus.dir, 0);
    model_reset();
    repeat (2) cyc();
    #2 rst = 1'b1;
    repeat (6) cyc();
    hold(2'b11, 4);
    check("post_rst_count", bus.count, 1);
    check("post_rst_dir",   bus.dir, 1);

    // forward wrap 15 -> 0
    do_load(15);
    hold(2'b10, 4);
    check("wrap_up_count", bus.count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
